// File: rtl/vec_pkg.sv
// Shared types and width helpers for the vector MAC sequencer.
package vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mac_state_e;

  localparam int unsigned els_def    = 16;
  localparam int unsigned el_w_def   = $clog2(els_def);
  localparam int unsigned vlen_w_def = $clog2(els_def + 1);

  // Element index width; at least one bit so single-element builds still have a port.
  function automatic int unsigned el_w_f(input int unsigned els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  // Vector length width; must hold the value els itself.
  function automatic int unsigned vlen_w_f(input int unsigned els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/mac_seq_el_ctr.sv
// Element issue counter: load resets to 0 and captures the last index, inc steps by one.
module mac_seq_el_ctr #(
  parameter int unsigned el_w = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [el_w-1:0] last_el_i,
  output logic [el_w-1:0] el_o,
  output logic            last_c
);

  logic [el_w-1:0] el_q;
  logic [el_w-1:0] last_q;

  // Current element and captured final index.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      el_q   <= '0;
      last_q <= '0;
    end else if (load_i) begin
      el_q   <= '0;
      last_q <= last_el_i;
    end else if (inc_i) begin
      el_q   <= el_q + el_w'(1);
    end
  end

  assign el_o   = el_q;
  assign last_c = (el_q == last_q);

endmodule

// File: rtl/mac_seq.sv
// Vector multiply-accumulate sequencer: reads R0/R1/R2 element k, feeds an external
// combinational MAC, writes R3[k] three cycles after acceptance, one element per cycle.
// Optional build macro MAC_SEQ_PERF_EN adds a 32-bit written-element counter perf_els_o.
module mac_seq
  import vec_pkg::*;
#(
  parameter int unsigned vdw_p     = 32,
  parameter int unsigned els_p     = els_def,
  parameter int unsigned raddr_w_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cmd_v_i,
  output logic                        cmd_ready_o,
  input  logic [vlen_w_f(els_p)-1:0]  cmd_vlen_i,
  input  logic [raddr_w_p-1:0]        cmd_src0_i,
  input  logic [raddr_w_p-1:0]        cmd_src1_i,
  input  logic [raddr_w_p-1:0]        cmd_src2_i,
  input  logic [raddr_w_p-1:0]        cmd_dst_i,
  output logic                        rd_v_o,
  output logic [el_w_f(els_p)-1:0]    rd_el_o,
  output logic [raddr_w_p-1:0]        rd_addr0_o,
  output logic [raddr_w_p-1:0]        rd_addr1_o,
  output logic [raddr_w_p-1:0]        rd_addr2_o,
  input  logic [vdw_p-1:0]            rd_data0_i,
  input  logic [vdw_p-1:0]            rd_data1_i,
  input  logic [vdw_p-1:0]            rd_data2_i,
  output logic [vdw_p-1:0]            mac_r0_o,
  output logic [vdw_p-1:0]            mac_r1_o,
  output logic [vdw_p-1:0]            mac_r2_o,
  input  logic [vdw_p-1:0]            mac_result_i,
  output logic                        wr_v_o,
  output logic [raddr_w_p-1:0]        wr_addr_o,
  output logic [el_w_f(els_p)-1:0]    wr_el_o,
  output logic [vdw_p-1:0]            wr_data_o,
  output logic                        busy_o,
  output logic                        done_o
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]                 perf_els_o
`endif
);

  localparam int unsigned el_w   = el_w_f(els_p);
  localparam int unsigned vlen_w = vlen_w_f(els_p);
  localparam logic [vlen_w-1:0] els_max = vlen_w'(els_p);

  mac_state_e state_q, state_n;

  logic              accept_c;
  logic              ctr_load_c;
  logic              ctr_inc_c;
  logic              ctr_last_c;
  logic [el_w-1:0]   ctr_el;
  logic [vlen_w-1:0] vlen_clamp_c;
  logic [el_w-1:0]   last_el_c;
  logic              vlen_zero_c;

  logic                 ready_q, busy_q, rd_v_q, done_q;
  logic [raddr_w_p-1:0] src0_q, src1_q, src2_q, dst_q;
  logic                 op_v_q, op_last_q;
  logic [el_w-1:0]      op_el_q;
  logic                 wr_v_q;
  logic [el_w-1:0]      wr_el_q;
  logic [vdw_p-1:0]     wr_data_q;

  assign vlen_clamp_c = (cmd_vlen_i > els_max) ? els_max : cmd_vlen_i;
  assign vlen_zero_c  = (vlen_clamp_c == '0);
  assign last_el_c    = el_w'(vlen_clamp_c - vlen_w'(1));

  mac_seq_el_ctr #(
    .el_w(el_w)
  ) u_el_ctr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (ctr_load_c),
    .inc_i     (ctr_inc_c),
    .last_el_i (last_el_c),
    .el_o      (ctr_el),
    .last_c    (ctr_last_c)
  );

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_n;
  end

  // Next state, acceptance and counter control.
  always_comb begin
    state_n    = state_q;
    accept_c   = 1'b0;
    ctr_load_c = 1'b0;
    ctr_inc_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_v_i) begin
          accept_c   = 1'b1;
          ctr_load_c = 1'b1;
          state_n    = vlen_zero_c ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (ctr_last_c) state_n   = ST_DRAIN;
        else            ctr_inc_c = 1'b1;
      end
      ST_DRAIN: begin
        if (done_q) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Command latch, status flags and the operand/write pipeline.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      rd_v_q    <= 1'b0;
      done_q    <= 1'b0;
      src0_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      dst_q     <= '0;
      op_v_q    <= 1'b0;
      op_last_q <= 1'b0;
      op_el_q   <= '0;
      wr_v_q    <= 1'b0;
      wr_el_q   <= '0;
      wr_data_q <= '0;
    end else begin
      ready_q   <= (state_n == ST_IDLE);
      busy_q    <= (state_n != ST_IDLE);
      rd_v_q    <= (state_n == ST_RUN);
      if (accept_c) begin
        src0_q <= cmd_src0_i;
        src1_q <= cmd_src1_i;
        src2_q <= cmd_src2_i;
        dst_q  <= cmd_dst_i;
      end
      op_v_q    <= rd_v_q;
      op_el_q   <= ctr_el;
      op_last_q <= rd_v_q & ctr_last_c;
      wr_v_q    <= op_v_q;
      if (op_v_q) begin
        wr_el_q   <= op_el_q;
        wr_data_q <= mac_result_i;
      end
      // Zero-length commands complete straight away; otherwise with the last write.
      done_q    <= (accept_c & vlen_zero_c) | (op_v_q & op_last_q);
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_v_o      = rd_v_q;
  assign rd_el_o     = ctr_el;
  assign rd_addr0_o  = src0_q;
  assign rd_addr1_o  = src1_q;
  assign rd_addr2_o  = src2_q;
  assign mac_r0_o    = op_v_q ? rd_data0_i : '0;
  assign mac_r1_o    = op_v_q ? rd_data1_i : '0;
  assign mac_r2_o    = op_v_q ? rd_data2_i : '0;
  assign wr_v_o      = wr_v_q;
  assign wr_addr_o   = dst_q;
  assign wr_el_o     = wr_el_q;
  assign wr_data_o   = wr_data_q;

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Count written elements, wrapping naturally.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     perf_q <= '0;
    else if (wr_v_q) perf_q <= perf_q + 32'd1;
  end

  assign perf_els_o = perf_q;
`endif

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter vdw_p, default 32, element data width.
REQ-002 Parameter els_p, default 16, maximum vector length in elements.
REQ-003 Parameter raddr_w_p, default 5, vector register address width.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 reset_i  in  1  asynchronous, active-high reset.
REQ-006 cmd_v_i / cmd_ready_o  in / out  1 / 1  command valid/ready handshake.
REQ-007 cmd_vlen_i  in  $clog2(els_p+1)  element count.
REQ-008 cmd_src0_i, cmd_src1_i, cmd_src2_i, cmd_dst_i  in  raddr_w_p each  R0, R1, R2, R3 register numbers.
REQ-009 rd_v_o  out  1  register-file read strobe.
REQ-010 rd_el_o  out  $clog2(els_p)  element index.
REQ-011 rd_addr0_o, rd_addr1_o, rd_addr2_o  out  raddr_w_p each  read register numbers.
REQ-012 rd_data0_i, rd_data1_i, rd_data2_i  in  vdw_p each  read data, valid exactly one cycle after rd_v_o.
REQ-013 mac_r0_o, mac_r1_o, mac_r2_o  out  vdw_p each  operands to the combinational multiply-add unit.
REQ-014 mac_result_i  in  vdw_p  R0*R1+R2, low vdw_p bits.
REQ-015 wr_v_o  out  1  write strobe.
REQ-016 wr_addr_o  out  raddr_w_p  destination register.
REQ-017 wr_el_o  out  $clog2(els_p)  destination element.
REQ-018 wr_data_o  out  vdw_p  write data.
REQ-019 busy_o / done_o  out  1 / 1  command in flight / one-cycle completion pulse.

Function
REQ-020 States IDLE, RUN, DRAIN; cmd_ready_o SHALL be 1 only in IDLE, and busy_o SHALL be 1 in RUN or DRAIN.
REQ-021 Acceptance (cmd_v_i & cmd_ready_o) at cycle 0 SHALL latch all cmd fields.
REQ-022 Acceptance SHALL clamp vlen to els_p.
REQ-023 Acceptance SHALL enter RUN, or DRAIN when vlen is 0.
REQ-024 In RUN, one element k SHALL be issued per cycle, k = 0..vlen-1, at cycle k+1.
REQ-025 Each issue cycle SHALL drive rd_v_o=1, rd_el_o=k and latched src0/1/2.
REQ-026 RUN SHALL transition to DRAIN after issuing k=vlen-1.
REQ-027 At cycle k+2, mac_r0_o/r1_o/r2_o SHALL equal rd_data0_i/1_i/2_i combinationally.
REQ-028 mac_result_i SHALL be registered at the end of cycle k+2.
REQ-029 At cycle k+3, the block SHALL drive wr_v_o=1, wr_el_o=k, wr_addr_o=latched dst and wr_data_o=registered result.
REQ-030 Throughput SHALL be one element per cycle, with fixed latency of 3 cycles from acceptance to first write.
REQ-031 DRAIN SHALL last until the final write, and done_o SHALL pulse in the cycle of the last wr_v_o.
REQ-032 With vlen=0, there SHALL be no reads or writes; done_o SHALL pulse at cycle 1 and the block SHALL return to IDLE at cycle 2.
REQ-033 A new command SHALL NOT be accepted until the cycle after done_o.
REQ-034 cmd_v_i outside IDLE SHALL be ignored.
REQ-035 dst equal to any src SHALL be legal; element k SHALL always be read before element k is written.
REQ-036 mac_r*_o SHALL be 0 when no element is in the operand stage.

Reset
REQ-037 reset_i SHALL force IDLE asynchronously.
REQ-038 During reset: cmd_ready_o=1 after reset, all other outputs 0, pipeline valids cleared.
REQ-039 Reset mid-command SHALL abort the command with no further rd_v_o, wr_v_o or done_o.

Configuration
REQ-040 With MAC_SEQ_PERF_EN defined, the block SHALL add output perf_els_o (32 bits), reset to 0, incremented on each wr_v_o, wrapping at 2^32.
REQ-041 Without MAC_SEQ_PERF_EN, the port and counter SHALL be absent.

Structure
REQ-042 Package vec_pkg SHALL hold the state enum typedef and the element-index and vlen width constants.
REQ-043 The element issue counter SHALL be one sub-module, mac_seq_el_ctr (load, increment, last flag).

Verification
REQ-044 Scenario: vlen=4, src 1/2/3, dst 4, model rf with R1[k]=k+1, R2[k]=2, R3[k]=10 -> writes at cycles 3..6, data 12,14,16,18, done_o at cycle 6.
REQ-045 Scenario: vlen=0 -> no rd_v_o or wr_v_o, done_o at cycle 1, cmd_ready_o=1 at cycle 2.
REQ-046 Scenario: vlen=20 with els_p=16 -> exactly 16 reads and 16 writes, el 0..15.
REQ-047 Scenario: back-to-back commands held on cmd_v_i -> second accepted the cycle after first done_o; no overlap of wr_v_o streams.
REQ-048 Scenario: reset_i asserted at cycle 3 of a vlen=8 command -> all outputs 0 immediately, no later writes, cmd_ready_o=1 after release.
REQ-049 Scenario: MAC_SEQ_PERF_EN, two vlen=5 commands -> perf_els_o=10.
